lcg_stim_sequencer: RTL
=======================

Name: lcg_stim_sequencer

Overview:
- Synthesizable stimulus scheduler for the fuzz harness.
- Owns the 32-bit LCG and fills the DUT's flat input vector one 32-bit word per cycle.
- Presents each completed vector to the DUT-side consumer through a valid/ready handshake.
- Counts issued vectors and reports completion, so the fuzz campaign can run on-chip or in emulation without a behavioural testbench loop.

Parameters:
- IN_W, 264, width of the flat stimulus vector driven into the DUT.
- DEF_SEED, 965067727, LCG state loaded at reset.
- WORDS, ceil(IN_W/32) (derived localparam, 9 at default), LCG words per vector.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle, ignored otherwise.
- abort  in  1  returns to IDLE the next cycle from any state.
- seed_load  in  1  when idle, loads seed_in into the LCG state.
- seed_in  in  32  seed value.
- num_cycles  in  32  number of post-initial vectors; sampled on start.
- in_flat  out  IN_W  current stimulus vector (to DUT in_flat).
- vec_valid  out  1  in_flat holds a new, unconsumed vector.
- vec_ready  in  1  consumer accepts the vector when vec_valid&&vec_ready.
- busy  out  1  high in FILL/PRESENT.
- done  out  1  one-cycle pulse after the last vector is accepted.
- vec_count  out  32  vectors accepted in this run.
- rng_state  out  32  current LCG state.

Behaviour:
- Reset (async, rst=1): state=IDLE; rng_state=DEF_SEED; in_flat=0; vec_valid=0; busy=0; done=0; vec_count=0; word index=0; remaining count=0.
- LCG step: s' = (s*32'h41C64E6D + 32'h3039) mod 2^32. Exactly one step per word produced; no steps in IDLE or PRESENT.
- Word k (k=0..WORDS-1) is the state after its step, written to in_flat[32k+31:32k]. The last word is truncated to its low (IN_W-32*(WORDS-1)) bits (8 at default).
- Words are written into a build register, not into in_flat. in_flat changes only on the FILL->PRESENT transition, so it is stable while vec_valid=1.
- IDLE:
  - seed_load=1 sets rng_state=seed_in.
  - start=1 latches total = num_cycles+1 (the initial vector plus num_cycles); clears vec_count; goes to FILL with word index 0.
  - If seed_load and start are both 1 in the same cycle, seed_load wins for this cycle: the seed is loaded and start is ignored.
- FILL:
  - Each cycle performs one step and writes word[index]; index increments.
  - After word WORDS-1: build register copies to in_flat, vec_valid=1, state goes to PRESENT.
  - Latency: start sampled at edge T gives the first word at T+1 and vec_valid=1 after edge T+WORDS.
- PRESENT:
  - Holds while vec_ready=0.
  - On handshake: vec_valid=0 and vec_count increments.
  - If vec_count+1==total, pulse done=1 for one cycle and go to IDLE. Otherwise go to FILL with index 0.
  - There is one free cycle between vectors: the handshake cycle does not step the LCG.
- abort (any state, priority over everything except rst): next state IDLE; vec_valid=0; done=0. rng_state, vec_count and in_flat keep their values.
- num_cycles=0: exactly one vector is issued.
- num_cycles=32'hFFFFFFFF: total wraps to 0. This is defined as unbounded; the run ends only on abort.
- busy = (state==FILL || state==PRESENT).
- vec_count saturates at 32'hFFFFFFFF.
- Reset mid-run returns all outputs to reset values immediately; no done pulse is produced.

Test Plan:
- Basic run: seed_load with seed_in=0, then start with num_cycles=0 and vec_ready=1 -> vec_valid first high 9 cycles after start; in_flat[31:0]=32'h00003039; in_flat[63:32]=32'hD3DC167E; done pulses once; vec_count=1; back in IDLE.
- Default seed: reset, then start with num_cycles=100 and vec_ready=1 -> 101 handshakes; 909 LCG steps; done on the final handshake only; a software LCG model matches every word, including the 8-bit truncated top word.
- Backpressure: hold vec_ready=0 for 20 cycles while vec_valid=1 -> in_flat and rng_state unchanged over those cycles; vec_count unchanged; resumes correctly when vec_ready=1.
- Abort mid-FILL at word 4 -> IDLE the next cycle; vec_valid=0; no done. A subsequent start continues from the retained rng_state, not from the seed.
- Async reset asserted between clock edges during PRESENT -> outputs return to reset values without waiting for a clock edge; rng_state=965067727.
- seed_load and start in the same cycle -> seed loaded, no run started, busy stays 0. start alone on the next cycle begins the run from the loaded seed.

Source files
------------

// File: rtl/lcg_stim_sequencer_if.sv
// Stimulus vector bus between the LCG sequencer (master) and the DUT-side consumer (slave).
interface lcg_stim_sequencer_if #(
  parameter int IN_W = 264
) ();
  logic [IN_W-1:0] in_flat;
  logic            vec_valid;
  logic            vec_ready;

  modport master (output in_flat, output vec_valid, input vec_ready);
  modport slave  (input in_flat, input vec_valid, output vec_ready);
endinterface

// File: rtl/lcg_stim_sequencer.sv
// On-chip fuzz stimulus scheduler: fills a flat vector one LCG word per cycle and
// hands completed vectors to the consumer over valid/ready, counting them per run.
module lcg_stim_sequencer #(
  parameter int          IN_W     = 264,
  parameter logic [31:0] DEF_SEED = 32'd965067727
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic                        i_seed_load,
  input  logic [31:0]                 i_seed_in,
  input  logic [31:0]                 i_num_cycles,
  lcg_stim_sequencer_if.master        o_vec,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [31:0]                 o_vec_count,
  output logic [31:0]                 o_rng_state
);
  localparam int WORDS   = (IN_W + 31) / 32;
  localparam int LAST_LO = 32 * (WORDS - 1);
  localparam int LAST_W  = IN_W - LAST_LO;
  localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, PRESENT} state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_rng, r_total, r_count;
  logic [IDX_W-1:0]  r_idx;
  logic [IN_W-1:0]   r_build, r_flat;
  logic              r_valid, r_done;

  logic [31:0]       w_rng_nxt, w_count_inc;
  logic [IN_W-1:0]   w_build_nxt;
  logic              w_seed_ld, w_run_start, w_step, w_fill_last, w_hs, w_final;

  assign w_rng_nxt   = r_rng * 32'h41C64E6D + 32'h3039;
  assign w_count_inc = r_count + 32'd1;

  // Splice the freshly stepped word into the build image; the top word is truncated.
  always_comb begin
    w_build_nxt = r_build;
    for (int k = 0; k < WORDS - 1; k++)
      if (r_idx == IDX_W'(k)) w_build_nxt[k*32 +: 32] = w_rng_nxt;
    if (r_idx == LAST_IDX) w_build_nxt[IN_W-1:LAST_LO] = w_rng_nxt[LAST_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_seed_ld   = 1'b0;
    w_run_start = 1'b0;
    w_step      = 1'b0;
    w_fill_last = 1'b0;
    w_hs        = 1'b0;
    w_final     = 1'b0;
    if (i_abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_seed_load) begin
            w_seed_ld = 1'b1;
          end else if (i_start) begin
            w_run_start = 1'b1;
            w_state_nxt = FILL;
          end
        end
        FILL: begin
          w_step = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_fill_last = 1'b1;
            w_state_nxt = PRESENT;
          end
        end
        PRESENT: begin
          if (o_vec.vec_ready) begin
            w_hs = 1'b1;
            // A total of zero means num_cycles wrapped: run until aborted.
            if (r_total != 32'd0 && w_count_inc == r_total) begin
              w_final     = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = FILL;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rng   <= DEF_SEED;
      r_total <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_build <= '0;
      r_flat  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_seed_ld) r_rng <= i_seed_in;
      if (w_run_start) begin
        r_total <= i_num_cycles + 32'd1;
        r_count <= '0;
        r_idx   <= '0;
      end
      if (w_step) begin
        r_rng   <= w_rng_nxt;
        r_build <= w_build_nxt;
        r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
      if (w_fill_last) begin
        r_flat  <= w_build_nxt;
        r_valid <= 1'b1;
      end
      if (w_hs) begin
        r_valid <= 1'b0;
        if (r_count != 32'hFFFF_FFFF) r_count <= w_count_inc;
      end
      if (i_abort) r_valid <= 1'b0;
    end
  end

  assign o_vec.in_flat   = r_flat;
  assign o_vec.vec_valid = r_valid;
  assign o_busy          = (r_state == FILL) || (r_state == PRESENT);
  assign o_done          = r_done;
  assign o_vec_count     = r_count;
  assign o_rng_state     = r_rng;
endmodule
